mig_app_responder: RTL and testbench
====================================

// Module: mig_app_responder
// PURPOSE
//  Synthesizable stand-in for the MIG user (app_*) interface. It is the responder end of the
//  port that ddr_controller drives. It answers read/write commands from on-chip block RAM with
//  a fixed read latency and optional injected back-pressure.
//  It lets the AP datapath run in simulation and on boards without DDR, without changing the controller.
// PARAMETERS
//  DDR_DATA_WIDTH   128  data beat width; mask width is DDR_DATA_WIDTH/8
//  DDR_ADDR_WIDTH   28   app_addr width
//  MEM_DEPTH_LOG2   10   log2 of RAM depth in beats
//  RD_LATENCY       4    cycles from read-command accept to app_rd_data_valid; legal range 2..15
//  WQ_DEPTH_LOG2    2    log2 depth of the write-data FIFO and of the write-address FIFO
//  CALIB_CYCLES     16   cycles after reset before init_calib_complete rises; must be >=1
//  STALL_PERIOD     0    app_rdy forced low one cycle in every STALL_PERIOD cycles; 0 = never
// PORTS
//  clk                  in   1     single clock for all logic
//  rst                  in   1     asynchronous, active-high reset
//  app_addr             in   DDR_ADDR_WIDTH   byte-style address; one beat per +8
//  app_cmd              in   3     3'b000 write, 3'b001 read, any other value illegal
//  app_en               in   1     command valid
//  app_rdy              out  1     command accepted when app_en & app_rdy
//  app_wdf_data         in   DDR_DATA_WIDTH   write data
//  app_wdf_mask         in   DDR_DATA_WIDTH/8 per byte: 1 = do NOT write that byte
//  app_wdf_wren         in   1     write-data valid
//  app_wdf_end          in   1     last beat of burst; must equal app_wdf_wren
//  app_wdf_rdy          out  1     write data accepted when app_wdf_wren & app_wdf_rdy
//  app_rd_data          out  DDR_DATA_WIDTH   read data
//  app_rd_data_valid    out  1     read-data strobe, one cycle per read command
//  init_calib_complete  out  1     interface ready
//  cmd_err              out  1     sticky error flag, cleared only by rst
//  wr_count / rd_count  out  16    executed write beats / read beats; both wrap at 2^16
// BEHAVIOUR
//  Reset values
//  - All outputs are 0 on rst: app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
//    init_calib_complete, cmd_err, wr_count, rd_count.
//  - FIFOs and the read pipeline are flushed and the calibration counter restarts.
//  - RAM contents are NOT cleared.
//  - A reset mid-burst discards all queued writes and all in-flight reads.
//  Calibration
//  - init_calib_complete rises on the CALIB_CYCLES-th rising edge after rst falls and stays 1 until the next rst.
//  - While init_calib_complete=0, app_rdy=0 and app_wdf_rdy=0.
//  Address mapping
//  - Beat index = app_addr[MEM_DEPTH_LOG2+2:3].
//  - Upper address bits are ignored, so addresses wrap modulo the RAM size.
//  Stall counter
//  - Free-running counter, active only when STALL_PERIOD>0.
//  - stall=1 on the cycle the counter equals STALL_PERIOD-1; the counter then wraps to 0.
//  app_rdy (combinational)
//  - app_rdy = calib & !stall & !waq_full & !(app_cmd==3'b001 & !waq_empty).
//  - Reads are therefore held off until all queued write commands have executed (read-after-write ordering).
//  app_wdf_rdy (combinational)
//  - app_wdf_rdy = calib & !wdq_full.
//  - Write data may arrive before, with, or after its command.
//  Write path
//  - An accepted write pushes the beat index into the write-address queue (waq).
//  - Accepted write data pushes {mask,data} into the write-data queue (wdq).
//  - When both queues are non-empty, both pop in the same cycle and the RAM is written with byte enables = ~mask.
//  - wr_count increments on that pop.
//  - Push and pop of the same queue in one cycle are legal; occupancy is unchanged.
//  Read path
//  - Reads are pipelined: one accept per cycle, fully overlapped, in-order returns, no bubbles.
//  - RAM is read on the accept edge; data is carried through a RD_LATENCY-1 stage valid/data pipeline.
//  - app_rd_data_valid is asserted exactly RD_LATENCY cycles after the accepting edge.
//  - app_rd_data holds its last value while valid is 0.
//  - rd_count increments when valid is asserted.
//  Error handling
//  - An illegal app_cmd with app_en & app_rdy is accepted and dropped, and sets cmd_err.
//  - app_wdf_wren & app_wdf_rdy with app_wdf_end=0 sets cmd_err; the beat is still queued.
//  - A write command whose data never arrives blocks every later read; this is by design (the controller sends data first).
// TESTING
//  1. rst low with CALIB_CYCLES=16: init_calib_complete=0 for 15 edges and 1 on the 16th;
//     app_rdy/app_wdf_rdy stay 0 until then.
//  2. Write 0xA5.. at addr 0x40, then read addr 0x40 with RD_LATENCY=4:
//     app_rd_data_valid high exactly 4 cycles after the read accept, data 0xA5..; wr_count=1, rd_count=1.
//  3. Mask 16'h00FF write of all-ones over a zero beat, then read: upper 8 bytes = FF, lower 8 bytes = 00.
//  4. Four write data beats with no command: app_wdf_rdy drops after the 4th.
//     Issue 4 write commands: the queues drain. A read issued meanwhile has app_rdy=0 until waq is empty.
//  5. Back-to-back reads of 8 beats with STALL_PERIOD=3: app_rdy is low every 3rd cycle;
//     all 8 beats return in order with correct data.
//  6. app_cmd=3'b011 with app_en: cmd_err=1 and no data returned.
//     Assert rst mid-read-burst: app_rd_data_valid=0 the next cycle, no stale beats afterwards, RAM data preserved.

Source files
------------

// File: rtl/mig_app_responder.sv
// mig_app_responder: BRAM-backed responder for the MIG app_* port, with
// fixed read latency, calibration delay and optional app_rdy stalls.
// Ports:
//   clk, rst                     clock, async active-high reset
//   app_addr/app_cmd/app_en      command in; app_rdy accepts
//   app_wdf_data/mask/wren/end   write data in; app_wdf_rdy accepts
//   app_rd_data/app_rd_data_valid read return
//   init_calib_complete, cmd_err, wr_count, rd_count status
module mig_app_responder #(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int RD_LATENCY     = 4,
  parameter int WQ_DEPTH_LOG2  = 2,
  parameter int CALIB_CYCLES   = 16,
  parameter int STALL_PERIOD   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DDR_ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]                  app_cmd,
  input  logic                        app_en,
  output logic                        app_rdy,
  input  logic [DDR_DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DDR_DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                        app_wdf_wren,
  input  logic                        app_wdf_end,
  output logic                        app_wdf_rdy,
  output logic [DDR_DATA_WIDTH-1:0]   app_rd_data,
  output logic                        app_rd_data_valid,
  output logic                        init_calib_complete,
  output logic                        cmd_err,
  output logic [15:0]                 wr_count,
  output logic [15:0]                 rd_count
);

  localparam int DW = DDR_DATA_WIDTH;
  localparam int MW = DDR_DATA_WIDTH / 8;
  localparam int AB = MEM_DEPTH_LOG2;
  localparam int QL = WQ_DEPTH_LOG2;
  localparam int QD = 1 << QL;
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  localparam int SW = (STALL_PERIOD > 1) ?
                      $clog2(STALL_PERIOD) : 1;

  logic [DW-1:0] mem [1 << AB];

  logic [AB-1:0] beat;
  logic          unused_addr;
  assign beat = app_addr[AB+2:3];
  assign unused_addr =
    ^{app_addr[DDR_ADDR_WIDTH-1:AB+3], app_addr[2:0]};

  logic [CW-1:0] cal_cnt;
  logic          calib;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cal_cnt <= '0;
      calib   <= 1'b0;
    end else if (!calib) begin
      if (cal_cnt == CW'(CALIB_CYCLES - 1))
        calib <= 1'b1;
      else
        cal_cnt <= cal_cnt + 1'b1;
    end
  end

  assign init_calib_complete = calib;

  logic stall;

  generate
    if (STALL_PERIOD > 0) begin : g_stall
      logic [SW-1:0] st_cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          st_cnt <= '0;
        else if (st_cnt == SW'(STALL_PERIOD - 1))
          st_cnt <= '0;
        else
          st_cnt <= st_cnt + 1'b1;
      end
      assign stall = (st_cnt == SW'(STALL_PERIOD - 1));
    end else begin : g_nostall
      assign stall = 1'b0;
    end
  endgenerate

  logic is_wr, is_rd, is_bad;

  always_comb begin
    is_wr  = 1'b0;
    is_rd  = 1'b0;
    is_bad = 1'b0;
    unique case (1'b1)
      (app_cmd == 3'b000): is_wr  = 1'b1;
      (app_cmd == 3'b001): is_rd  = 1'b1;
      default:             is_bad = 1'b1;
    endcase
  end

  logic [AB-1:0]    waq_mem [QD];
  logic [MW+DW-1:0] wdq_mem [QD];
  logic [QL:0]      waq_wp, waq_rp;
  logic [QL:0]      wdq_wp, wdq_rp;
  logic             waq_empty, waq_full;
  logic             wdq_empty, wdq_full;

  assign waq_empty = (waq_wp == waq_rp);
  assign wdq_empty = (wdq_wp == wdq_rp);
  assign waq_full  = (waq_wp[QL] != waq_rp[QL]) &&
                     (waq_wp[QL-1:0] == waq_rp[QL-1:0]);
  assign wdq_full  = (wdq_wp[QL] != wdq_rp[QL]) &&
                     (wdq_wp[QL-1:0] == wdq_rp[QL-1:0]);

  // Reads wait for an empty waq so they never overtake a queued write.
  assign app_rdy = calib & !stall & !waq_full &
                   !(is_rd & !waq_empty);
  assign app_wdf_rdy = calib & !wdq_full;

  logic cmd_acc, wr_acc, rd_acc, bad_acc, wd_acc, pop;

  assign cmd_acc = app_en & app_rdy;
  assign wr_acc  = cmd_acc & is_wr;
  assign rd_acc  = cmd_acc & is_rd;
  assign bad_acc = cmd_acc & is_bad;
  assign wd_acc  = app_wdf_wren & app_wdf_rdy;
  assign pop     = !waq_empty & !wdq_empty;

  logic [AB-1:0]    wq_addr;
  logic [MW+DW-1:0] wq_head;
  logic [MW-1:0]    wq_mask;
  logic [DW-1:0]    wq_data;

  assign wq_addr = waq_mem[waq_rp[QL-1:0]];
  assign wq_head = wdq_mem[wdq_rp[QL-1:0]];
  assign wq_mask = wq_head[MW+DW-1:DW];
  assign wq_data = wq_head[DW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waq_wp   <= '0;
      waq_rp   <= '0;
      wdq_wp   <= '0;
      wdq_rp   <= '0;
      wr_count <= '0;
      cmd_err  <= 1'b0;
    end else begin
      if (wr_acc) waq_wp <= waq_wp + 1'b1;
      if (wd_acc) wdq_wp <= wdq_wp + 1'b1;
      if (pop) begin
        waq_rp   <= waq_rp + 1'b1;
        wdq_rp   <= wdq_rp + 1'b1;
        wr_count <= wr_count + 16'd1;
      end
      if (bad_acc || (wd_acc && !app_wdf_end))
        cmd_err <= 1'b1;
    end
  end

  localparam int PL = RD_LATENCY - 1;

  logic          rd_v;
  logic [DW-1:0] rd_d;
  logic [PL-1:0] pv;
  logic [DW-1:0] pd [PL];

  // Storage and data-only pipeline: no reset, valids gate them.
  always_ff @(posedge clk) begin
    if (wr_acc) waq_mem[waq_wp[QL-1:0]] <= beat;
    if (wd_acc)
      wdq_mem[wdq_wp[QL-1:0]] <= {app_wdf_mask, app_wdf_data};
    if (pop) begin
      for (int b = 0; b < MW; b++)
        if (!wq_mask[b])
          mem[wq_addr][b*8 +: 8] <= wq_data[b*8 +: 8];
    end
    if (rd_acc) rd_d <= mem[beat];
    pd[0] <= rd_d;
    for (int i = 1; i < PL; i++)
      pd[i] <= pd[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v              <= 1'b0;
      pv                <= '0;
      app_rd_data_valid <= 1'b0;
      app_rd_data       <= '0;
      rd_count          <= '0;
    end else begin
      rd_v  <= rd_acc;
      pv[0] <= rd_v;
      for (int i = 1; i < PL; i++)
        pv[i] <= pv[i-1];
      app_rd_data_valid <= pv[PL-1];
      if (pv[PL-1]) begin
        app_rd_data <= pd[PL-1];
        rd_count    <= rd_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mig_app_responder.sv
// tb_mig_app_responder: vector table plus scoreboarded sequences
// for mig_app_responder (RD_LATENCY=4, STALL_PERIOD=3, CALIB=16).
module tb_mig_app_responder;

  localparam int DW  = 128;
  localparam int AW  = 28;
  localparam int MW  = 16;
  localparam int L   = 4;
  localparam int SP  = 3;
  localparam int CAL = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] app_addr = '0;
  logic [2:0]    app_cmd = '0;
  logic          app_en = 1'b0;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data = '0;
  logic [MW-1:0] app_wdf_mask = '0;
  logic          app_wdf_wren = 1'b0;
  logic          app_wdf_end = 1'b0;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          init_calib_complete;
  logic          cmd_err;
  logic [15:0]   wr_count, rd_count;

  always #5 clk = ~clk;

  mig_app_responder #(
    .RD_LATENCY(L), .CALIB_CYCLES(CAL), .STALL_PERIOD(SP)
  ) dut (
    .clk(clk), .rst(rst),
    .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid),
    .init_calib_complete(init_calib_complete),
    .cmd_err(cmd_err),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  typedef struct {
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] base;
    logic [DW-1:0] wdata;
    logic [MW-1:0] mask;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    int            cyc;
  } sb_t;

  sb_t           sb[$];
  logic [DW-1:0] model [int];
  logic [DW-1:0] last_d;
  vec_t          vecs [6];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc;
  int            exp_wr = 0;
  int            exp_rd = 0;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
    int b;
    b = int'(a[12:3]);
    if (model.exists(b)) return model[b];
    return 'x;
  endfunction

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(i);
    return {4{w}};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      last_d = '0;
    end else if (app_rd_data_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rd_valid", DW'(app_rd_data_valid), '0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("rd_data", app_rd_data, e.d);
        chk("rd_latency", DW'(cyc), DW'(e.cyc));
      end
      last_d = app_rd_data;
    end else begin
      chk("rd_hold", app_rd_data, last_d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_data(input logic [DW-1:0] d,
                           input logic [MW-1:0] m,
                           input logic e);
    bit ok;
    ok = 1'b0;
    app_wdf_data = d;
    app_wdf_mask = m;
    app_wdf_end  = e;
    app_wdf_wren = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = app_wdf_rdy;
      tick();
    end
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    chk("wdf_accept", DW'(ok), DW'(1));
  endtask

  task automatic send_cmd(input logic [2:0] c,
                          input logic [AW-1:0] a);
    bit ok;
    ok = 1'b0;
    app_cmd  = c;
    app_addr = a;
    app_en   = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = app_rdy;
      if (ok && c == 3'b001) begin
        sb.push_back('{mrd(a), cyc + 1 + L});
        exp_rd++;
      end
      tick();
    end
    app_en = 1'b0;
    chk("cmd_accept", DW'(ok), DW'(1));
  endtask

  task automatic do_write(input logic [AW-1:0] a,
                          input logic [DW-1:0] d,
                          input logic [MW-1:0] m,
                          input logic [DW-1:0] nv);
    send_data(d, m, 1'b1);
    send_cmd(3'b000, a);
    model[int'(a[12:3])] = nv;
    exp_wr++;
  endtask

  task automatic burst(input logic [AW-1:0] a,
                       input int n, input bit cs);
    int got;
    got = 0;
    app_cmd  = 3'b001;
    app_addr = a;
    app_en   = 1'b1;
    for (int i = 0; i < 60 && got < n; i++) begin
      @(negedge clk);
      if (cs)
        chk("stall_rdy", DW'(app_rdy),
            DW'((cyc % SP) != (SP - 1)));
      if (app_rdy) begin
        sb.push_back('{mrd(app_addr), cyc + 1 + L});
        exp_rd++;
        got++;
      end
      tick();
      app_addr = a + AW'(8 * got);
    end
    app_en = 1'b0;
    chk("burst_done", DW'(got), DW'(n));
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++)
      tick();
    repeat (3) tick();
    chk("drain", DW'(sb.size()), '0);
  endtask

  task automatic reset_chk();
    chk("rst_app_rdy", DW'(app_rdy), '0);
    chk("rst_wdf_rdy", DW'(app_wdf_rdy), '0);
    chk("rst_rd_data", app_rd_data, '0);
    chk("rst_rd_valid", DW'(app_rd_data_valid), '0);
    chk("rst_calib", DW'(init_calib_complete), '0);
    chk("rst_cmd_err", DW'(cmd_err), '0);
    chk("rst_wr_count", DW'(wr_count), '0);
    chk("rst_rd_count", DW'(rd_count), '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{28'h40, 28'h40, 128'h0, {16{8'hA5}},
                16'h0000, {16{8'hA5}}};
    vecs[1] = '{28'h80, 28'h80, 128'h0, {128{1'b1}},
                16'h00FF, {{8{8'hFF}}, {8{8'h00}}}};
    vecs[2] = '{28'h1FF8, 28'h1FF8, {128{1'b1}},
                {8{16'h1234}}, 16'hFF00,
                {{8{8'hFF}}, {4{16'h1234}}}};
    vecs[3] = '{28'h2040, 28'h40, 128'h0,
                {4{32'hDEADBEEF}}, 16'h0000,
                {4{32'hDEADBEEF}}};
    vecs[4] = '{28'hC0, 28'hC0, 128'h0, {128{1'b1}},
                16'h5555, {8{16'hFF00}}};
    vecs[5] = '{28'h108, 28'h108, {16{8'h3C}}, 128'h0,
                16'hFFFF, {16{8'h3C}}};

    repeat (3) tick();
    reset_chk();
    rst = 1'b0;
    for (int k = 1; k < CAL; k++) begin
      tick();
      chk("calib_low", DW'(init_calib_complete), '0);
    end
    chk("pre_calib_app_rdy", DW'(app_rdy), '0);
    chk("pre_calib_wdf_rdy", DW'(app_wdf_rdy), '0);
    tick();
    chk("calib_high", DW'(init_calib_complete), DW'(1));
    chk("calib_wdf_rdy", DW'(app_wdf_rdy), DW'(1));

    for (int v = 0; v < 6; v++) begin
      do_write(vecs[v].waddr, vecs[v].base, '0, vecs[v].base);
      do_write(vecs[v].waddr, vecs[v].wdata, vecs[v].mask,
               vecs[v].exp);
      send_cmd(3'b001, vecs[v].raddr);
    end
    drain();
    chk("wr_count_tbl", DW'(wr_count), DW'(exp_wr));
    chk("rd_count_tbl", DW'(rd_count), DW'(exp_rd));
    chk("cmd_err_none", DW'(cmd_err), '0);

    for (int i = 4; i < 8; i++)
      do_write(28'h100 + AW'(8 * i), pat(i), '0, pat(i));
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    app_wdf_mask = '0;
    for (int i = 0; i < 4; i++) begin
      app_wdf_data = pat(i);
      @(negedge clk);
      chk("wdf_rdy_fill", DW'(app_wdf_rdy), DW'(1));
      tick();
    end
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    @(negedge clk);
    chk("wdf_full", DW'(app_wdf_rdy), '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      send_cmd(3'b000, 28'h100 + AW'(8 * i));
      model[int'((28'h100 + 8 * i) >> 3)] = pat(i);
      exp_wr++;
    end
    app_cmd  = 3'b001;
    app_addr = 28'h100;
    app_en   = 1'b1;
    @(negedge clk);
    chk("raw_hold", DW'(app_rdy), '0);
    tick();
    send_cmd(3'b001, 28'h100);
    drain();
    chk("wdf_rdy_drained", DW'(app_wdf_rdy), DW'(1));
    chk("wr_count_q", DW'(wr_count), DW'(exp_wr));

    burst(28'h100, 8, 1'b1);
    drain();
    chk("rd_count_burst", DW'(rd_count), DW'(exp_rd));

    chk("cmd_err_pre", DW'(cmd_err), '0);
    send_cmd(3'b011, 28'h40);
    repeat (10) tick();
    chk("cmd_err_illegal", DW'(cmd_err), DW'(1));
    chk("rd_count_illegal", DW'(rd_count), DW'(exp_rd));

    burst(28'h100, 6, 1'b0);
    rst = 1'b1;
    sb.delete();
    exp_rd = 0;
    exp_wr = 0;
    #1;
    chk("rst_valid_now", DW'(app_rd_data_valid), '0);
    tick();
    reset_chk();
    rst = 1'b0;
    repeat (CAL) tick();
    chk("recalib", DW'(init_calib_complete), DW'(1));
    repeat (10) tick();
    send_cmd(3'b001, 28'h40);
    drain();
    chk("rd_count_post_rst", DW'(rd_count), DW'(1));

    send_data(pat(9), '0, 1'b0);
    tick();
    chk("cmd_err_no_end", DW'(cmd_err), DW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
